// File: rtl/noc_attention_control.sv
// Per-head sequencer for multi-head self-attention: load Q/K, score, softmax
// overlapped with the V fetch, context, then write the context slice.
module noc_attention_control #(
   parameter int NUM_HEADS      = 12,
   parameter int HEAD_W         = 4,
   parameter int TIMEOUT_CYCLES = 1048576,
   parameter int TO_W           = 21
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              done,
   output logic              error,
   output logic [2:0]        err_code,
   output logic [HEAD_W-1:0] head_idx,
   output logic              start_dma_q,
   output logic              start_dma_k,
   output logic              start_dma_v,
   output logic              start_dma_ctx,
   input  logic              dma_q_done,
   input  logic              dma_k_done,
   input  logic              dma_v_done,
   input  logic              dma_ctx_done,
   input  logic              dma_q_error,
   input  logic              dma_k_error,
   input  logic              dma_v_error,
   input  logic              dma_ctx_error,
   output logic              start_score,
   output logic              start_softmax,
   output logic              start_context,
   input  logic              score_done,
   input  logic              softmax_done,
   input  logic              context_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_QK, S_SCORE, S_SOFTMAX_V, S_CONTEXT, S_WRITE, S_DONE, S_ERROR
   } state_t;

   state_t            r_state, w_next;
   logic              r_first;
   logic              r_qDone, r_kDone, r_smDone, r_vDone;
   logic [TO_W-1:0]   r_wd;
   logic              r_done, r_error;
   logic [2:0]        r_errCode;
   logic [HEAD_W-1:0] r_head;

   logic       w_wait, w_timeout, w_sample;
   logic       w_qSeen, w_kSeen, w_smSeen, w_vSeen;
   logic       w_qErr, w_kErr, w_vErr, w_ctxErr;
   logic       w_accept, w_errSet, w_doneSet, w_headInc, w_enter;
   logic [2:0] w_errCode;

   // r_first marks the strobe cycle; completions and errors count only after it
   assign w_sample  = !r_first;
   assign w_wait    = r_state inside {S_LOAD_QK, S_SCORE, S_SOFTMAX_V, S_CONTEXT, S_WRITE};
   assign w_timeout = w_wait && (r_wd == TO_W'(TIMEOUT_CYCLES - 1));

   assign w_qSeen  = r_qDone  || (r_state == S_LOAD_QK   && w_sample && dma_q_done);
   assign w_kSeen  = r_kDone  || (r_state == S_LOAD_QK   && w_sample && dma_k_done);
   assign w_smSeen = r_smDone || (r_state == S_SOFTMAX_V && w_sample && softmax_done);
   assign w_vSeen  = r_vDone  || (r_state == S_SOFTMAX_V && w_sample && dma_v_done);

   assign w_qErr   = r_state == S_LOAD_QK   && w_sample && !r_qDone && dma_q_error;
   assign w_kErr   = r_state == S_LOAD_QK   && w_sample && !r_kDone && dma_k_error;
   assign w_vErr   = r_state == S_SOFTMAX_V && w_sample && !r_vDone && dma_v_error;
   assign w_ctxErr = r_state == S_WRITE     && w_sample && dma_ctx_error;

   assign start_dma_q   = r_first && r_state == S_LOAD_QK;
   assign start_dma_k   = r_first && r_state == S_LOAD_QK;
   assign start_score   = r_first && r_state == S_SCORE;
   assign start_softmax = r_first && r_state == S_SOFTMAX_V;
   assign start_dma_v   = r_first && r_state == S_SOFTMAX_V;
   assign start_context = r_first && r_state == S_CONTEXT;
   assign start_dma_ctx = r_first && r_state == S_WRITE;

   assign done     = r_done;
   assign error    = r_error;
   assign err_code = r_errCode;
   assign head_idx = r_head;

   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_errSet  = 1'b0;
      w_errCode = 3'd0;
      w_doneSet = 1'b0;
      w_headInc = 1'b0;
      case (r_state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = S_LOAD_QK;
            end
         end
         S_LOAD_QK: begin
            if (w_qErr) begin
               w_errSet = 1'b1; w_errCode = 3'd1; w_next = S_ERROR;
            end else if (w_kErr) begin
               w_errSet = 1'b1; w_errCode = 3'd2; w_next = S_ERROR;
            end else if (w_qSeen && w_kSeen) begin
               w_next = S_SCORE;
            end
         end
         S_SCORE: begin
            if (w_sample && score_done) w_next = S_SOFTMAX_V;
         end
         S_SOFTMAX_V: begin
            if (w_vErr) begin
               w_errSet = 1'b1; w_errCode = 3'd3; w_next = S_ERROR;
            end else if (w_smSeen && w_vSeen) begin
               w_next = S_CONTEXT;
            end
         end
         S_CONTEXT: begin
            if (w_sample && context_done) w_next = S_WRITE;
         end
         S_WRITE: begin
            if (w_ctxErr) begin
               w_errSet = 1'b1; w_errCode = 3'd4; w_next = S_ERROR;
            end else if (w_sample && dma_ctx_done) begin
               if (r_head == HEAD_W'(NUM_HEADS - 1)) begin
                  w_doneSet = 1'b1;
                  w_next    = S_DONE;
               end else begin
                  w_headInc = 1'b1;
                  w_next    = S_LOAD_QK;
               end
            end
         end
         default: w_next = S_IDLE;
      endcase
      // Watchdog fires only when nothing else moved the sequencer this cycle
      if (w_timeout && w_next == r_state && !w_headInc) begin
         w_errSet  = 1'b1;
         w_errCode = 3'd5;
         w_next    = S_ERROR;
      end
   end

   // A head advance re-enters LOAD_QK, so it counts as a fresh entry too
   assign w_enter = (w_next != r_state) || w_headInc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_first   <= 1'b0;
         r_qDone   <= 1'b0;
         r_kDone   <= 1'b0;
         r_smDone  <= 1'b0;
         r_vDone   <= 1'b0;
         r_wd      <= '0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
         r_errCode <= 3'd0;
         r_head    <= '0;
      end else begin
         r_state <= w_next;
         r_first <= w_enter;
         if (w_enter) begin
            r_qDone  <= 1'b0;
            r_kDone  <= 1'b0;
            r_smDone <= 1'b0;
            r_vDone  <= 1'b0;
            r_wd     <= '0;
         end else begin
            r_qDone  <= w_qSeen;
            r_kDone  <= w_kSeen;
            r_smDone <= w_smSeen;
            r_vDone  <= w_vSeen;
            if (w_wait) r_wd <= r_wd + 1'b1;
         end
         if (w_accept) begin
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_errCode <= 3'd0;
            r_head    <= '0;
         end
         if (w_errSet) begin
            r_error   <= 1'b1;
            r_errCode <= w_errCode;
         end
         if (w_doneSet) r_done <= 1'b1;
         if (w_headInc) r_head <= r_head + 1'b1;
      end
   end

endmodule
